// File: rtl/fetch_unit.sv
// fetch_unit: issues in-order instruction fetches at pc_in and buffers the returned words for decode.
// Optional build macro FETCH_STALL_CNT_EN adds a 32-bit saturating stall_cnt output.
module fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_advance,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, DRAIN} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     discard_q, discard_d;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]     tag_wr_q, tag_rd_q, fifo_wr_q, fifo_rd_q;
  logic [ADDR_W-1:0] tag_mem  [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [CW:0] in_use;
  logic        credit_ok, accept, rsp_fire, rsp_keep, inst_pop;
  logic        unused_redirect_pc;

  // The PC module loads the branch target itself; only the flush matters here.
  assign unused_redirect_pc = ^redirect_pc;

  assign in_use    = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
  assign credit_ok = in_use < DEPTH[CW:0];

  // Qualified by reset so no request or PC step escapes while reset is held.
  assign imem_req_valid = reset && (state_q == RUN) && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc_in;
  assign accept         = imem_req_valid && imem_req_ready;
  assign pc_advance     = accept;

  assign rsp_fire   = imem_rsp_valid && (outstanding_q != '0);
  assign rsp_keep   = rsp_fire && (discard_q == '0) && !redirect_valid;
  assign inst_valid = fifo_cnt_q != '0;
  assign inst_pop   = inst_valid && inst_ready;
  assign inst_data  = inst_valid ? data_mem[fifo_rd_q] : '0;
  assign inst_pc    = inst_valid ? pc_mem[fifo_rd_q]   : '0;

  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    fifo_cnt_d    = fifo_cnt_q;
    if (accept && !rsp_fire)      outstanding_d = outstanding_q + CW'(1);
    else if (!accept && rsp_fire) outstanding_d = outstanding_q - CW'(1);
    if (redirect_valid) begin
      discard_d  = outstanding_q - CW'(rsp_fire);
      fifo_cnt_d = '0;
      state_d    = (discard_d != '0) ? DRAIN : RUN;
    end else begin
      if (rsp_fire && (discard_q != '0)) discard_d = discard_q - CW'(1);
      fifo_cnt_d = fifo_cnt_q + CW'(rsp_keep) - CW'(inst_pop);
      if ((state_q == DRAIN) && (discard_q == '0)) state_d = RUN;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      outstanding_q <= '0;
      discard_q     <= '0;
      fifo_cnt_q    <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      fifo_wr_q     <= '0;
      fifo_rd_q     <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fifo_cnt_q    <= fifo_cnt_d;
      if (accept)   tag_wr_q <= tag_wr_q + PW'(1);
      if (rsp_fire) tag_rd_q <= tag_rd_q + PW'(1);
      if (redirect_valid) begin
        fifo_wr_q <= '0;
        fifo_rd_q <= '0;
      end else begin
        if (rsp_keep) fifo_wr_q <= fifo_wr_q + PW'(1);
        if (inst_pop) fifo_rd_q <= fifo_rd_q + PW'(1);
      end
    end
  end

  // NOTE: storage arrays are not reset; counts and pointers define validity and outputs are gated.
  always_ff @(posedge clk) begin
    if (accept) tag_mem[tag_wr_q] <= pc_in;
    if (rsp_keep) begin
      pc_mem[fifo_wr_q]   <= tag_mem[tag_rd_q];
      data_mem[fifo_wr_q] <= imem_rsp_data;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic stall_evt;
  assign stall_evt = (imem_req_valid && !imem_req_ready) ||
                     ((state_q == RUN) && !redirect_valid && !credit_ok);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               stall_cnt <= '0;
    else if (stall_evt && (stall_cnt != '1))  stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model plus scoreboard queue checked by a separate monitor.
// Build with FETCH_STALL_CNT_EN defined to also exercise stall_cnt.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_advance;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_in          (pc_in),
    .pc_advance     (pc_advance),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  mreq_t       mem_q[$];
  exp_t        exp_q[$];
  logic [31:0] acc_log[$];
  logic [31:0] pop_log[$];
  logic [31:0] pc_model;
  int total = 0, bad = 0, cyc = 0, lat = 1, adv_cnt = 0;
  int first_rsp_cyc = -1, first_inst_cyc = -1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs change 1 time unit after the rising edge and hold for the whole cycle.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    redirect_valid = 1'b0;
    pc_in = pc_model;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  // Environment: memory model, PC model and scoreboard pushes for what the next edge commits.
  initial forever begin
    @(negedge clk);
    #1;
    if (!reset) begin
      mem_q.delete();
      exp_q.delete();
    end else begin
      if (imem_rsp_valid && mem_q.size() != 0) begin
        void'(mem_q.pop_front());
        if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
      end
      if (imem_req_valid && imem_req_ready) begin
        mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
        exp_q.push_back('{pc: pc_in, data: mem_word(pc_in)});
        acc_log.push_back(imem_req_addr);
      end
      if (pc_advance) begin
        adv_cnt++;
        pc_model = pc_model + 32'd4;
      end
      if (redirect_valid) begin
        exp_q.delete();
        pc_model = redirect_pc;
      end
    end
  end

  // Monitor: compares each consumed instruction against the scoreboard head.
  initial forever begin
    @(negedge clk);
    if (reset && inst_valid) begin
      if (first_inst_cyc < 0) first_inst_cyc = cyc;
      if (inst_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL inst_unexpected: got pc 0x%0h with no expected entry (cycle %0d)", inst_pc, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("inst_pc", 64'(inst_pc), 64'(e.pc));
          check("inst_data", 64'(inst_data), 64'(e.data));
        end
        pop_log.push_back(inst_pc);
      end
    end
  end

  initial begin
    logic [31:0] first_pop;
    reset = 1'b0; pc_model = '0; pc_in = '0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b1;
    #1;
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_pc_advance", 64'(pc_advance), 64'd0);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_inst_data", 64'(inst_data), 64'd0);
    check("rst_inst_pc", 64'(inst_pc), 64'd0);
`ifdef FETCH_STALL_CNT_EN
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    repeat (2) step();

    // Streaming: ready memory, 1-cycle latency, decode always ready.
    reset = 1'b1;
    repeat (8) step();
    check("t1_adv_cnt", 64'(adv_cnt), 64'd8);
    check("t1_acc_n", 64'(acc_log.size()), 64'd8);
    if (acc_log.size() >= 3) begin
      check("t1_addr0", 64'(acc_log[0]), 64'h0);
      check("t1_addr1", 64'(acc_log[1]), 64'h4);
      check("t1_addr2", 64'(acc_log[2]), 64'h8);
    end
    check("t1_rsp_to_inst", 64'(first_inst_cyc), 64'(first_rsp_cyc + 1));
    imem_req_ready = 1'b0;
    repeat (4) step();
    check("t1_sb_empty", 64'(exp_q.size()), 64'd0);
    check("t1_idle", 64'(inst_valid), 64'd0);

    // Credit limit: decode stalled, exactly DEPTH requests accepted.
    acc_log.delete();
    imem_req_ready = 1'b1; inst_ready = 1'b0;
    repeat (8) step();
    #1;
    check("t2_acc_n", 64'(acc_log.size()), 64'd4);
    check("t2_req_blocked", 64'(imem_req_valid), 64'd0);
    check("t2_adv_blocked", 64'(pc_advance), 64'd0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    repeat (5) step();
    #1;
    check("t2_one_credit", 64'(acc_log.size()), 64'd5);
    check("t2_req_blocked2", 64'(imem_req_valid), 64'd0);
    imem_req_ready = 1'b0; inst_ready = 1'b1;
    repeat (8) step();
    check("t2_sb_empty", 64'(exp_q.size()), 64'd0);

    // Redirect with 3 outstanding and 1 buffered, 4-cycle memory latency.
    lat = 4; inst_ready = 1'b0; imem_req_ready = 1'b1;
    repeat (5) step();
    #1;
    check("t3_buffered", 64'(inst_valid), 64'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h40; pop_log.delete();
    #1;
    check("t3_no_req_redirect", 64'(imem_req_valid), 64'd0);
    step();
    #1;
    check("t3_flushed", 64'(inst_valid), 64'd0);
    inst_ready = 1'b1; lat = 1;
    repeat (2) step();
    #1;
    check("t3_drain_no_req", 64'(imem_req_valid), 64'd0);
    step();
    #1;
    check("t3_resume_req", 64'(imem_req_valid), 64'd1);
    check("t3_resume_addr", 64'(imem_req_addr), 64'h40);
    repeat (5) step();
    check("t3_pop_seen", 64'(pop_log.size() != 0), 64'd1);
    first_pop = (pop_log.size() != 0) ? pop_log[0] : 32'hDEAD_DEAD;
    check("t3_first_inst_pc", 64'(first_pop), 64'h40);

    // Redirect coinciding with the only outstanding response.
    imem_req_ready = 1'b0;
    repeat (4) step();
    lat = 2; imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h80; pop_log.delete();
    #1;
    check("t4_no_req_redirect", 64'(imem_req_valid), 64'd0);
    step();
    imem_req_ready = 1'b1;
    #1;
    check("t4_run_req", 64'(imem_req_valid), 64'd1);
    check("t4_run_addr", 64'(imem_req_addr), 64'h80);
    check("t4_dropped", 64'(inst_valid), 64'd0);
    step();
    imem_req_ready = 1'b0;
    repeat (4) step();
    check("t4_pop_n", 64'(pop_log.size()), 64'd1);
    first_pop = (pop_log.size() != 0) ? pop_log[0] : 32'hDEAD_DEAD;
    check("t4_inst_pc", 64'(first_pop), 64'h80);

    // Ready toggling 1,0,0,1: PC steps only on accepted cycles, address holds meanwhile.
    imem_req_ready = 1'b1;
    #1;
    check("t5_adv_c1", 64'(pc_advance), 64'd1);
    check("t5_addr_c1", 64'(imem_req_addr), 64'h84);
    step();
    imem_req_ready = 1'b0;
    #1;
    check("t5_adv_c2", 64'(pc_advance), 64'd0);
    check("t5_addr_c2", 64'(imem_req_addr), 64'h88);
    step();
    #1;
    check("t5_adv_c3", 64'(pc_advance), 64'd0);
    check("t5_addr_c3", 64'(imem_req_addr), 64'h88);
    step();
    imem_req_ready = 1'b1;
    #1;
    check("t5_adv_c4", 64'(pc_advance), 64'd1);
    check("t5_addr_c4", 64'(imem_req_addr), 64'h88);
    step();
    imem_req_ready = 1'b0;
    repeat (5) step();
    check("t5_sb_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset with 2 outstanding and 2 buffered.
    inst_ready = 1'b0; imem_req_ready = 1'b1;
    repeat (4) step();
    #1;
    check("t6_pre_buffered", 64'(inst_valid), 64'd1);
    reset = 1'b0;
    #1;
    check("t6_inst_valid", 64'(inst_valid), 64'd0);
    check("t6_req_valid", 64'(imem_req_valid), 64'd0);
    check("t6_inst_pc", 64'(inst_pc), 64'd0);
`ifdef FETCH_STALL_CNT_EN
    check("t6_stall_clr", 64'(stall_cnt), 64'd0);
`endif
    pc_model = 32'h100;
    step();
    imem_req_ready = 1'b0; reset = 1'b1;
    repeat (2) step();
    #1;
`ifdef FETCH_STALL_CNT_EN
    check("t6_stall_cnt2", 64'(stall_cnt), 64'd2);
`endif
    check("t6_req_after", 64'(imem_req_valid), 64'd1);
    check("t6_addr_after", 64'(imem_req_addr), 64'h100);
    imem_req_ready = 1'b1; inst_ready = 1'b1; pop_log.delete();
    step();
    imem_req_ready = 1'b0;
    repeat (5) step();
    first_pop = (pop_log.size() != 0) ? pop_log[0] : 32'hDEAD_DEAD;
    check("t6_restart_pc", 64'(first_pop), 64'h100);
    check("t6_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
